rv32i_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback over a single shared memory port. It drives every datapath enable, the mux selects and the ALU operation code (alu_ops) decoded from the latched instruction. It also flags illegal encodings and counts retired instructions.

---
 rtl/rv32i_pkg.sv | 61 ++++++
 rtl/rv32i_alu_decode.sv | 81 ++++++++
 rtl/rv32i_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I multi-cycle control path: sequencer states,
// base opcodes, ALU operation codes and datapath mux encodings.
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6,
    ST_HALT      = 3'd7
  } ctrl_state_t;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [5:0] {
    ALU_NOP    = 6'd0,
    ALU_ADD    = 6'd1,
    ALU_SUB    = 6'd2,
    ALU_SLL    = 6'd3,
    ALU_SLT    = 6'd4,
    ALU_SLTU   = 6'd5,
    ALU_XOR    = 6'd6,
    ALU_SRL    = 6'd7,
    ALU_SRA    = 6'd8,
    ALU_OR     = 6'd9,
    ALU_AND    = 6'd10,
    ALU_ADDI   = 6'd11,
    ALU_SLTI   = 6'd12,
    ALU_SLTIU  = 6'd13,
    ALU_XORI   = 6'd14,
    ALU_ORI    = 6'd15,
    ALU_ANDI   = 6'd16,
    ALU_BYPASS = 6'd17,
    ALU_JALR   = 6'd18
  } alu_op_t;

  localparam logic       PC_SEL_PLUS4 = 1'b0;
  localparam logic       PC_SEL_ALU   = 1'b1;

  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_MEM   = 2'd1;
  localparam logic [1:0] WB_SEL_PC4   = 2'd2;

  localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

endpackage

// File: rtl/rv32i_alu_decode.sv
// Combinational opcode/funct3/funct7 decode: produces the ALU operation for
// EXECUTE and flags any encoding outside the supported RV32I subset.
module rv32i_alu_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_t    alu_op_o,
  output logic       legal_o
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_op_o = ALU_NOP;
    legal_o  = 1'b1;
    case (opcode_i)
      OPC_LUI:   alu_op_o = ALU_BYPASS;
      OPC_AUIPC: alu_op_o = ALU_ADD;
      OPC_JAL:   alu_op_o = ALU_ADD;
      OPC_JALR: begin
        alu_op_o = ALU_JALR;
        legal_o  = (funct3_i == 3'b000);
      end
      OPC_BRANCH: begin
        alu_op_o = ALU_ADD;
        legal_o  = (funct3_i != 3'b010) && (funct3_i != 3'b011);
      end
      OPC_LOAD, OPC_STORE: begin
        alu_op_o = ALU_ADD;
        legal_o  = (funct3_i == 3'b010);
      end
      OPC_OP_IMM: begin
        case (funct3_i)
          3'b000: alu_op_o = ALU_ADDI;
          3'b001: begin
            alu_op_o = ALU_SLL;
            legal_o  = (funct7_i == FUNCT7_BASE);
          end
          3'b010: alu_op_o = ALU_SLTI;
          3'b011: alu_op_o = ALU_SLTIU;
          3'b100: alu_op_o = ALU_XORI;
          3'b101: begin
            if (funct7_i == FUNCT7_BASE)     alu_op_o = ALU_SRL;
            else if (funct7_i == FUNCT7_ALT) alu_op_o = ALU_SRA;
            else                             legal_o  = 1'b0;
          end
          3'b110: alu_op_o = ALU_ORI;
          default: alu_op_o = ALU_ANDI;
        endcase
      end
      OPC_OP: begin
        if (funct7_i == FUNCT7_BASE) begin
          case (funct3_i)
            3'b000: alu_op_o = ALU_ADD;
            3'b001: alu_op_o = ALU_SLL;
            3'b010: alu_op_o = ALU_SLT;
            3'b011: alu_op_o = ALU_SLTU;
            3'b100: alu_op_o = ALU_XOR;
            3'b101: alu_op_o = ALU_SRL;
            3'b110: alu_op_o = ALU_OR;
            default: alu_op_o = ALU_AND;
          endcase
        end else if (funct7_i == FUNCT7_ALT) begin
          // The alternate funct7 only exists for SUB and SRA.
          case (funct3_i)
            3'b000:  alu_op_o = ALU_SUB;
            3'b101:  alu_op_o = ALU_SRA;
            default: legal_o  = 1'b0;
          endcase
        end else begin
          legal_o = 1'b0;
        end
      end
      OPC_SYSTEM: alu_op_o = ALU_NOP;
      default:    legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/mem/writeback over
// one shared memory port, with sticky trap/halt states and a retire counter.
module rv32i_ctrl_fsm
  import rv32i_pkg::*;
#(
  parameter int unsigned RESET_IDLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [5:0]  alu_op,
  output logic        alu_out_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        halted,
  output logic        retire,
  output logic [31:0] retire_count
);

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  ctrl_state_t state_q;
  logic [3:0]  idle_cnt_q;
  logic [31:0] retire_count_q;
  logic        halt_retired_q;

  alu_op_t     dec_alu_op;
  alu_op_t     alu_op_c;
  logic        dec_legal;
  logic [6:0]  opcode;
  logic        is_branch, is_load, is_store, is_system, is_jump, is_auipc, is_op;
  logic        unused_instr_bits;

  assign opcode    = instr[6:0];
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_op     = (opcode == OPC_OP);

  // Register specifiers and immediates are consumed by the datapath, not here.
  assign unused_instr_bits = ^instr[24:15];

  rv32i_alu_decode u_alu_decode (
    .opcode_i (opcode),
    .funct3_i (instr[14:12]),
    .funct7_i (instr[31:25]),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idle_cnt_q     <= '0;
      retire_count_q <= '0;
      halt_retired_q <= 1'b0;
    end else begin
      if (retire) retire_count_q <= retire_count_q + 32'd1;
      case (state_q)
        ST_IDLE: begin
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_q <= '0;
            state_q    <= ST_FETCH;
          end else begin
            idle_cnt_q <= idle_cnt_q + 4'd1;
          end
        end
        ST_FETCH: if (mem_ready) state_q <= ST_DECODE;
        ST_DECODE: begin
          if (!dec_legal)     state_q <= ST_TRAP;
          else if (is_system) state_q <= ST_HALT;
          else                state_q <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (is_branch)                 state_q <= ST_FETCH;
          else if (is_load || is_store)  state_q <= ST_MEM;
          else                           state_q <= ST_WRITEBACK;
        end
        ST_MEM: if (mem_ready) state_q <= is_load ? ST_WRITEBACK : ST_FETCH;
        ST_WRITEBACK: state_q <= ST_FETCH;
        ST_TRAP:      state_q <= ST_TRAP;
        ST_HALT:      halt_retired_q <= 1'b1;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so an asynchronous reset
  // drops every enable (mem_req included) without waiting for a clock.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op_c     = ALU_NOP;
    alu_out_we   = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    illegal      = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXECUTE: begin
        alu_out_we = 1'b1;
        alu_op_c   = dec_alu_op;
        alu_a_sel  = is_auipc || (opcode == OPC_JAL) || is_branch;
        alu_b_sel  = !is_op;
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (is_store && mem_ready) begin
          pc_we  = 1'b1;
          pc_sel = PC_SEL_PLUS4;
          retire = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        rf_we  = (instr[11:7] != 5'd0);
        pc_we  = 1'b1;
        retire = 1'b1;
        pc_sel = is_jump ? PC_SEL_ALU : PC_SEL_PLUS4;
        if (is_load)      wb_sel = WB_SEL_MEM;
        else if (is_jump) wb_sel = WB_SEL_PC4;
        else              wb_sel = WB_SEL_ALU;
      end
      ST_TRAP: illegal = 1'b1;
      ST_HALT: begin
        halted = 1'b1;
        retire = !halt_retired_q;
      end
      default: ;
    endcase
  end

  assign alu_op       = alu_op_c;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed bench for rv32i_ctrl_fsm: walks hand-encoded instructions through
// the sequencer and checks every control output cycle by cycle.
module tb_rv32i_ctrl_fsm;
  import rv32i_pkg::*;

  localparam int IDLE_N = 3;

  localparam logic [15:0] MREQ  = 16'h8000;
  localparam logic [15:0] MWE   = 16'h4000;
  localparam logic [15:0] MADDR = 16'h2000;
  localparam logic [15:0] IRWE  = 16'h1000;
  localparam logic [15:0] PCWE  = 16'h0800;
  localparam logic [15:0] PCSEL = 16'h0400;
  localparam logic [15:0] ASEL  = 16'h0200;
  localparam logic [15:0] BSEL  = 16'h0100;
  localparam logic [15:0] AOW   = 16'h0080;
  localparam logic [15:0] RFWE  = 16'h0040;
  localparam logic [15:0] WBPC4 = 16'h0020;
  localparam logic [15:0] WBMEM = 16'h0010;
  localparam logic [15:0] ILL   = 16'h0008;
  localparam logic [15:0] HLT   = 16'h0004;
  localparam logic [15:0] RET   = 16'h0002;
  localparam logic [15:0] NONE  = 16'h0000;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_ADDI0  = 32'h0010_0013;
  localparam logic [31:0] I_BEQ    = 32'h0000_0463;
  localparam logic [31:0] I_SW     = 32'h0020_A223;
  localparam logic [31:0] I_LW     = 32'h0040_A183;
  localparam logic [31:0] I_JAL    = 32'h0100_00EF;
  localparam logic [31:0] I_SUB    = 32'h4073_02B3;
  localparam logic [31:0] I_BADSUB = 32'h4273_02B3;
  localparam logic [31:0] I_BADOPC = 32'h0000_007F;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
  logic        alu_a_sel, alu_b_sel, alu_out_we, rf_we;
  logic [5:0]  alu_op;
  logic [1:0]  wb_sel;
  logic        illegal, halted, retire;
  logic [31:0] retire_count;
  logic [15:0] obs_ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_ctrl_fsm #(.RESET_IDLE_CYCLES(IDLE_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .alu_out_we   (alu_out_we),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .halted       (halted),
    .retire       (retire),
    .retire_count (retire_count)
  );

  assign obs_ctl = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                    alu_a_sel, alu_b_sel, alu_out_we, rf_we, wb_sel,
                    illegal, halted, retire, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then sample outputs.
  task automatic step(input string tag, input logic rdy, input logic bt,
                      input logic [15:0] ctl, input alu_op_t op);
    @(negedge clk);
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
    check({tag, "/ctl"}, 32'(obs_ctl), 32'(ctl));
    check({tag, "/op"},  32'(alu_op),  32'(op));
  endtask

  // Called right after a sample point; moves past the next rising edge.
  task automatic check_cnt(input string tag, input logic [31:0] exp);
    #5;
    check(tag, retire_count, exp);
  endtask

  // Releases reset and checks the IDLE dwell, with mem_ready held high to show
  // it is ignored while no request is outstanding.
  task automatic release_rst(input string tag);
    @(negedge clk);
    rst          = 1'b0;
    mem_ready    = 1'b1;
    branch_taken = 1'b0;
    #1;
    check({tag, "/idle0"}, 32'(obs_ctl), 32'(NONE));
    for (int i = 1; i < IDLE_N; i++) step({tag, "/idle"}, 1'b1, 1'b0, NONE, ALU_NOP);
  endtask

  task automatic assert_rst_now(input string tag);
    #1;
    rst = 1'b1;
    #1;
    check({tag, "/ctl"}, 32'(obs_ctl), 32'(NONE));
    check({tag, "/op"},  32'(alu_op),  32'(ALU_NOP));
    check({tag, "/cnt"}, retire_count, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    instr        = 32'd0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    #12;
    check("reset/ctl", 32'(obs_ctl), 32'(NONE));
    check("reset/op",  32'(alu_op),  32'(ALU_NOP));
    check("reset/cnt", retire_count, 32'd0);
    release_rst("boot");

    // ADDI x1,x0,5 with a one-cycle-late fetch
    instr = I_ADDI;
    step("addi/f0",  1'b0, 1'b0, MREQ,             ALU_NOP);
    step("addi/f1",  1'b1, 1'b0, MREQ | IRWE,      ALU_NOP);
    step("addi/dec", 1'b0, 1'b0, NONE,             ALU_NOP);
    step("addi/ex",  1'b0, 1'b0, BSEL | AOW,       ALU_ADDI);
    step("addi/wb",  1'b0, 1'b0, PCWE | RFWE | RET, ALU_NOP);
    check_cnt("addi/cnt", 32'd1);

    // BEQ taken, then not taken; no WRITEBACK in between
    instr = I_BEQ;
    step("beqt/f",   1'b1, 1'b0, MREQ | IRWE, ALU_NOP);
    step("beqt/dec", 1'b0, 1'b1, NONE,        ALU_NOP);
    step("beqt/ex",  1'b0, 1'b1, ASEL | BSEL | AOW | PCWE | PCSEL | RET, ALU_ADD);
    check_cnt("beqt/cnt", 32'd2);
    step("beqn/f",   1'b1, 1'b0, MREQ | IRWE, ALU_NOP);
    step("beqn/dec", 1'b0, 1'b0, NONE,        ALU_NOP);
    step("beqn/ex",  1'b0, 1'b0, ASEL | BSEL | AOW | PCWE | RET, ALU_ADD);
    check_cnt("beqn/cnt", 32'd3);

    // SW with one wait state
    instr = I_SW;
    step("sw/f",   1'b1, 1'b0, MREQ | IRWE,         ALU_NOP);
    step("sw/dec", 1'b0, 1'b0, NONE,                ALU_NOP);
    step("sw/ex",  1'b0, 1'b0, BSEL | AOW,          ALU_ADD);
    step("sw/m0",  1'b0, 1'b0, MREQ | MWE | MADDR,  ALU_NOP);
    step("sw/m1",  1'b1, 1'b0, MREQ | MWE | MADDR | PCWE | RET, ALU_NOP);
    check_cnt("sw/cnt", 32'd4);

    // LW with three wait states: 5+3 cycles
    instr = I_LW;
    step("lw/f",   1'b1, 1'b0, MREQ | IRWE,  ALU_NOP);
    step("lw/dec", 1'b0, 1'b0, NONE,         ALU_NOP);
    step("lw/ex",  1'b0, 1'b0, BSEL | AOW,   ALU_ADD);
    for (int i = 0; i < 3; i++) step("lw/mw", 1'b0, 1'b0, MREQ | MADDR, ALU_NOP);
    step("lw/m",   1'b1, 1'b0, MREQ | MADDR, ALU_NOP);
    step("lw/wb",  1'b0, 1'b0, RFWE | PCWE | RET | WBMEM, ALU_NOP);
    check_cnt("lw/cnt", 32'd5);

    instr = I_JAL;
    step("jal/f",   1'b1, 1'b0, MREQ | IRWE,       ALU_NOP);
    step("jal/dec", 1'b0, 1'b0, NONE,              ALU_NOP);
    step("jal/ex",  1'b0, 1'b0, ASEL | BSEL | AOW, ALU_ADD);
    step("jal/wb",  1'b0, 1'b0, RFWE | PCWE | PCSEL | WBPC4 | RET, ALU_NOP);
    check_cnt("jal/cnt", 32'd6);

    instr = I_SUB;
    step("sub/f",   1'b1, 1'b0, MREQ | IRWE,       ALU_NOP);
    step("sub/dec", 1'b0, 1'b0, NONE,              ALU_NOP);
    step("sub/ex",  1'b0, 1'b0, AOW,               ALU_SUB);
    step("sub/wb",  1'b0, 1'b0, RFWE | PCWE | RET, ALU_NOP);
    check_cnt("sub/cnt", 32'd7);

    // rd = x0 suppresses the register write
    instr = I_ADDI0;
    step("addix0/f",   1'b1, 1'b0, MREQ | IRWE, ALU_NOP);
    step("addix0/dec", 1'b0, 1'b0, NONE,        ALU_NOP);
    step("addix0/ex",  1'b0, 1'b0, BSEL | AOW,  ALU_ADDI);
    step("addix0/wb",  1'b0, 1'b0, PCWE | RET,  ALU_NOP);
    check_cnt("addix0/cnt", 32'd8);

    // Reset asserted in the middle of a load's memory access
    instr = I_LW;
    step("lwrst/f",   1'b1, 1'b0, MREQ | IRWE,  ALU_NOP);
    step("lwrst/dec", 1'b0, 1'b0, NONE,         ALU_NOP);
    step("lwrst/ex",  1'b0, 1'b0, BSEL | AOW,   ALU_ADD);
    step("lwrst/m",   1'b0, 1'b0, MREQ | MADDR, ALU_NOP);
    assert_rst_now("lwrst/rst");
    release_rst("lwrst");

    // Counter wrap: preload the all-ones value while fetch is stalled
    instr = I_ADDI;
    step("wrap/f0", 1'b0, 1'b0, MREQ, ALU_NOP);
    dut.retire_count_q = 32'hFFFF_FFFF;
    step("wrap/f1",  1'b1, 1'b0, MREQ | IRWE,       ALU_NOP);
    step("wrap/dec", 1'b0, 1'b0, NONE,              ALU_NOP);
    step("wrap/ex",  1'b0, 1'b0, BSEL | AOW,        ALU_ADDI);
    step("wrap/wb",  1'b0, 1'b0, PCWE | RFWE | RET, ALU_NOP);
    check_cnt("wrap/cnt", 32'd0);

    // Unknown opcode traps and stays trapped
    instr = I_BADOPC;
    step("badopc/f",   1'b1, 1'b0, MREQ | IRWE, ALU_NOP);
    step("badopc/dec", 1'b0, 1'b0, NONE,        ALU_NOP);
    for (int i = 0; i < 3; i++) step("badopc/trap", 1'b1, 1'b1, ILL, ALU_NOP);
    assert_rst_now("badopc/rst");
    release_rst("badopc");

    // R-type with funct7=0100001 traps
    instr = I_BADSUB;
    step("badsub/f",   1'b1, 1'b0, MREQ | IRWE, ALU_NOP);
    step("badsub/dec", 1'b0, 1'b0, NONE,        ALU_NOP);
    for (int i = 0; i < 3; i++) step("badsub/trap", 1'b1, 1'b1, ILL, ALU_NOP);
    assert_rst_now("badsub/rst");
    release_rst("badsub");

    // ECALL halts with exactly one retire pulse
    instr = I_ECALL;
    step("ecall/f",   1'b1, 1'b0, MREQ | IRWE, ALU_NOP);
    step("ecall/dec", 1'b0, 1'b0, NONE,        ALU_NOP);
    step("ecall/h0",  1'b1, 1'b0, HLT | RET,   ALU_NOP);
    check_cnt("ecall/cnt0", 32'd1);
    for (int i = 0; i < 3; i++) step("ecall/halt", 1'b1, 1'b0, HLT, ALU_NOP);
    check_cnt("ecall/cnt1", 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
